// File: rtl/fp_mult_pipe.sv
// Pipelined fixed-point multiplier with valid/ready flow control, optional
// round-half-up and saturation, and a sideband tag carried alongside each sample.
module fp_mult_pipe #(
  parameter int N        = 24,
  parameter int Q        = 10,
  parameter int SIGNED   = 1,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1,
  parameter int LATENCY  = 3,
  parameter int TAG_W    = 4
) (
  input  logic             clock_in,
  input  logic             reset_n_in,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     result_out,
  output logic             overflow_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PW     = 2 * N;
  localparam int W      = 2 * N + 1;
  localparam int RND_SH = (Q > 0) ? Q - 1 : 0;
  localparam logic [W-1:0] RND_V = (ROUND != 0 && Q > 0) ?
                                   ({{(W-1){1'b0}}, 1'b1} << RND_SH) : {W{1'b0}};

  // Full-width product; operands are sign- or zero-extended to 2N bits first.
  function automatic logic [PW-1:0] mult_f(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    ax = {{N{(SIGNED != 0) & a[N-1]}}, a};
    bx = {{N{(SIGNED != 0) & b[N-1]}}, b};
    return ax * bx;
  endfunction

  // Round, rescale and range-limit a product; returns {overflow, result}.
  function automatic logic [N:0] post_f(input logic [PW-1:0] p);
    logic [W-1:0] ext_v;
    logic [W-1:0] sh_v;
    logic         ovf_v;
    logic [N-1:0] res_v;
    ext_v = {(SIGNED != 0) & p[PW-1], p} + RND_V;
    if (SIGNED != 0) begin
      sh_v  = $signed(ext_v) >>> Q;
      ovf_v = ~((&sh_v[W-1:N-1]) | ~(|sh_v[W-1:N-1]));
    end else begin
      sh_v  = ext_v >> Q;
      ovf_v = |sh_v[W-1:N];
    end
    if (ovf_v && SATURATE != 0) begin
      if (SIGNED == 0) begin
        res_v = {N{1'b1}};
      end else if (sh_v[W-1]) begin
        res_v = {1'b1, {(N-1){1'b0}}};
      end else begin
        res_v = {1'b0, {(N-1){1'b1}}};
      end
    end else begin
      res_v = sh_v[N-1:0];
    end
    return {ovf_v, res_v};
  endfunction

  logic             stall_s;
  logic [PW-1:0]    src_prod_s;
  logic [TAG_W-1:0] src_tag_s;
  logic             src_valid_s;

  // A held output freezes the whole pipe; bubbles are kept, never squeezed out.
  assign stall_s  = out_valid & ~out_ready;
  assign in_ready = ~stall_s;

  generate
    if (LATENCY > 1) begin : g_pipe
      localparam int D = LATENCY - 1;
      logic [PW-1:0]    prod_r  [D];
      logic [TAG_W-1:0] tag_r   [D];
      logic [D-1:0]     valid_r;

      // Product delay line ahead of the round/saturate output stage.
      always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
          for (int i = 0; i < D; i++) begin
            prod_r[i] <= {PW{1'b0}};
            tag_r[i]  <= {TAG_W{1'b0}};
          end
          valid_r <= {D{1'b0}};
        end else if (!stall_s) begin
          prod_r[0]  <= mult_f(a_in, b_in);
          tag_r[0]   <= tag_in;
          valid_r[0] <= in_valid;
          for (int i = 1; i < D; i++) begin
            prod_r[i]  <= prod_r[i-1];
            tag_r[i]   <= tag_r[i-1];
            valid_r[i] <= valid_r[i-1];
          end
        end
      end

      assign src_prod_s  = prod_r[D-1];
      assign src_tag_s   = tag_r[D-1];
      assign src_valid_s = valid_r[D-1];
    end else begin : g_direct
      assign src_prod_s  = mult_f(a_in, b_in);
      assign src_tag_s   = tag_in;
      assign src_valid_s = in_valid;
    end
  endgenerate

  // Output stage: rounding and saturation land directly in the output register.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      out_valid    <= 1'b0;
      result_out   <= {N{1'b0}};
      overflow_out <= 1'b0;
      tag_out      <= {TAG_W{1'b0}};
    end else if (!stall_s) begin
      out_valid <= src_valid_s;
      if (src_valid_s) begin
        {overflow_out, result_out} <= post_f(src_prod_s);
        tag_out                    <= src_tag_s;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Randomised and directed bench for fp_mult_pipe: four configurations share one
// input stream, each checked against an integer-arithmetic reference model.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] a = 24'd0;
  logic [23:0] b = 24'd0;
  logic [3:0]  tag = 4'd0;
  logic        in_valid = 1'b0;
  logic        ordy_a = 1'b1;

  logic        ir_a, ir_b, ir_c, ir_d;
  logic        ov_a, ov_b, ov_c, ov_d;
  logic        of_a, of_b, of_c, of_d;
  logic [23:0] res_a, res_b, res_c;
  logic [7:0]  res_d;
  logic [3:0]  tg_a, tg_b, tg_c, tg_d;

  always #5 clk = ~clk;

  fp_mult_pipe u_a (
    .clock_in(clk), .reset_n_in(rst_n), .a_in(a), .b_in(b), .tag_in(tag),
    .in_valid(in_valid), .in_ready(ir_a), .result_out(res_a), .overflow_out(of_a),
    .tag_out(tg_a), .out_valid(ov_a), .out_ready(ordy_a));

  fp_mult_pipe #(.ROUND(0)) u_b (
    .clock_in(clk), .reset_n_in(rst_n), .a_in(a), .b_in(b), .tag_in(tag),
    .in_valid(in_valid), .in_ready(ir_b), .result_out(res_b), .overflow_out(of_b),
    .tag_out(tg_b), .out_valid(ov_b), .out_ready(1'b1));

  fp_mult_pipe #(.SATURATE(0)) u_c (
    .clock_in(clk), .reset_n_in(rst_n), .a_in(a), .b_in(b), .tag_in(tag),
    .in_valid(in_valid), .in_ready(ir_c), .result_out(res_c), .overflow_out(of_c),
    .tag_out(tg_c), .out_valid(ov_c), .out_ready(1'b1));

  fp_mult_pipe #(.N(8), .Q(4), .SIGNED(0), .LATENCY(1)) u_d (
    .clock_in(clk), .reset_n_in(rst_n), .a_in(a[7:0]), .b_in(b[7:0]), .tag_in(tag),
    .in_valid(in_valid), .in_ready(ir_d), .result_out(res_d), .overflow_out(of_d),
    .tag_out(tg_d), .out_valid(ov_d), .out_ready(1'b1));

  int cfg_n   [4] = '{24, 24, 24, 8};
  int cfg_q   [4] = '{10, 10, 10, 4};
  int cfg_s   [4] = '{1, 1, 1, 0};
  int cfg_r   [4] = '{1, 0, 1, 1};
  int cfg_sat [4] = '{1, 1, 0, 1};
  int cfg_l   [4] = '{3, 3, 3, 1};

  typedef struct {
    logic [23:0] r;
    logic        o;
    logic [3:0]  t;
    int          acc;
    int          st;
  } exp_t;

  exp_t sb [4][$];
  int   stall_cnt [4] = '{0, 0, 0, 0};
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic rnd_done;

  task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h at cycle %0d", name, obs, expv, cyc);
    end
  endtask

  // Reference: exact integer product, optional +half LSB, floor shift, range clamp.
  function automatic void model(input int id, input logic [23:0] ain, input logic [23:0] bin,
                                output logic [23:0] r, output logic o);
    longint n, q, msk, av, bv, v, lo, hi;
    n   = cfg_n[id];
    q   = cfg_q[id];
    msk = (longint'(1) << n) - 1;
    av  = longint'(ain) & msk;
    bv  = longint'(bin) & msk;
    if (cfg_s[id] != 0) begin
      if (av >= (longint'(1) << (n - 1))) av -= (longint'(1) << n);
      if (bv >= (longint'(1) << (n - 1))) bv -= (longint'(1) << n);
      lo = -(longint'(1) << (n - 1));
      hi = (longint'(1) << (n - 1)) - 1;
    end else begin
      lo = 0;
      hi = msk;
    end
    v = av * bv;
    if (cfg_r[id] != 0 && q > 0) v += longint'(1) << (q - 1);
    v = v >>> q;
    o = (v < lo) || (v > hi);
    if (o && cfg_sat[id] != 0) v = (v > hi) ? hi : lo;
    r = 24'(v & msk);
  endfunction

  task automatic mon(input int id, input logic irdy, input logic oval, input logic ordy,
                     input logic [23:0] r, input logic o, input logic [3:0] t);
    exp_t        e;
    logic        stl;
    logic        exp_ir;
    logic [23:0] er;
    logic        eo;
    stl    = oval & ~ordy;
    exp_ir = ~stl;
    check_val($sformatf("in_ready%0d", id), {31'd0, irdy}, {31'd0, exp_ir});
    if (oval) begin
      if (sb[id].size() == 0) begin
        check_val($sformatf("spurious%0d", id), {31'd0, oval}, 32'd0);
      end else begin
        e = sb[id][0];
        check_val($sformatf("result%0d", id), {8'd0, r}, {8'd0, e.r});
        check_val($sformatf("ovf%0d", id), {31'd0, o}, {31'd0, e.o});
        check_val($sformatf("tag%0d", id), {28'd0, t}, {28'd0, e.t});
        if (ordy) begin
          check_val($sformatf("latency%0d", id), cyc - e.acc - (stall_cnt[id] - e.st), cfg_l[id]);
          void'(sb[id].pop_front());
        end
      end
    end
    if (in_valid && irdy) begin
      model(id, a, b, er, eo);
      e = '{r: er, o: eo, t: tag, acc: cyc, st: stall_cnt[id]};
      sb[id].push_back(e);
    end
    stall_cnt[id] += int'(stl);
  endtask

  // Cycle counter used to timestamp accepts and consumes.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ir_a, ov_a, ordy_a, res_a, of_a, tg_a);
      mon(1, ir_b, ov_b, 1'b1, res_b, of_b, tg_b);
      mon(2, ir_c, ov_c, 1'b1, res_c, of_c, tg_c);
      mon(3, ir_d, ov_d, 1'b1, {16'd0, res_d}, of_d, tg_d);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] av, input logic [23:0] bv, input logic [3:0] tv);
    logic got;
    got      = 1'b0;
    a        = av;
    b        = bv;
    tag      = tv;
    in_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (ir_a) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_val("send_timeout", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int left;
    ordy_a = 1'b1;
    left   = 0;
    for (int k = 0; k < 2000; k++) begin
      left = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
      if (left == 0) break;
      idle(1);
    end
    check_val("drain", left, 32'd0);
  endtask

  task automatic chk_zero(input string nm, input logic oval, input logic [23:0] r,
                          input logic o, input logic [3:0] t);
    check_val({nm, "_rst_valid"}, {31'd0, oval}, 32'd0);
    check_val({nm, "_rst_result"}, {8'd0, r}, 32'd0);
    check_val({nm, "_rst_ovf"}, {31'd0, o}, 32'd0);
    check_val({nm, "_rst_tag"}, {28'd0, t}, 32'd0);
  endtask

  function automatic logic [23:0] pick();
    logic [23:0] v;
    logic [11:0] lo12;
    case ($urandom_range(0, 3))
      0: v = 24'($urandom);
      1: begin
        lo12 = 12'($urandom);
        v    = {{12{lo12[11]}}, lo12};
      end
      2: case ($urandom_range(0, 3))
           0: v = 24'h7FFFFF;
           1: v = 24'h800000;
           2: v = 24'hFFFFFF;
           default: v = 24'h000001;
         endcase
      default: v = 24'($urandom_range(0, 2047));
    endcase
    return v;
  endfunction

  initial begin
    // Reset state
    #12;
    chk_zero("a", ov_a, res_a, of_a, tg_a);
    chk_zero("d", ov_d, {16'd0, res_d}, of_d, tg_d);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("in_ready_after_rst", {31'd0, ir_a}, 32'd1);

    // Directed vectors, full throughput
    send(24'h000600, 24'h000800, 4'h1);
    send(24'hFFFA00, 24'h000800, 4'h2);
    send(24'h000001, 24'h000200, 4'h3);
    send(24'hFFFFFF, 24'h000200, 4'h4);
    send(24'h400000, 24'h400000, 4'h5);
    send(24'h400000, 24'hC00000, 4'h6);
    send(24'h0000F0, 24'h000020, 4'h7);
    send(24'h000018, 24'h000018, 4'h8);
    drain();

    // Backpressure: out_ready low for cycles 4..6 of an 8-sample burst
    fork
      begin
        for (int i = 0; i < 8; i++) send(24'(32'h000400 * (i + 1)), 24'h000C00, 4'(i));
      end
      begin
        idle(4);
        ordy_a = 1'b0;
        idle(3);
        ordy_a = 1'b1;
      end
    join
    drain();

    // Randomised stream with random gaps and backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(pick(), pick(), 4'($urandom));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          ordy_a = ($urandom_range(0, 9) < 7);
          idle(1);
        end
      end
    join
    drain();

    // Reset with three samples in flight
    send(24'h000600, 24'h000800, 4'hA);
    send(24'h000700, 24'h000800, 4'hB);
    send(24'h000800, 24'h000800, 4'hC);
    #2;
    rst_n = 1'b0;
    for (int id = 0; id < 4; id++) sb[id].delete();
    #1;
    chk_zero("a_mid", ov_a, res_a, of_a, tg_a);
    chk_zero("b_mid", ov_b, res_b, of_b, tg_b);
    chk_zero("d_mid", ov_d, {16'd0, res_d}, of_d, tg_d);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check_val("in_ready_after_rst2", {31'd0, ir_a}, 32'd1);
    send(24'h000C00, 24'h000400, 4'hD);
    drain();
    idle(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
